// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the instruction fetch and the data stage.
// MEM has priority; IF is forced through after STARVE_MAX back-to-back MEM grants.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk_i,
  input  logic              rst_n,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_valid_o,
  output logic              if_stall_o,
  input  logic              flush_i,
  input  logic              mem_req_i,
  input  logic              mem_we_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  output logic [DATA_W-1:0] mem_rdata_o,
  output logic              mem_valid_o,
  output logic              mem_stall_o,
  output logic              mport_req_o,
  output logic              mport_we_o,
  output logic [ADDR_W-1:0] mport_addr_o,
  output logic [DATA_W-1:0] mport_wdata_o,
  input  logic              mport_ack_i,
  input  logic [DATA_W-1:0] mport_rdata_i
);

  localparam int unsigned     CNT_W      = 3;
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SERVE_IF  = 2'd1,
    SERVE_MEM = 2'd2
  } state_t;

  state_t              r_state,       w_state_nxt;
  logic [CNT_W-1:0]    r_starve,      w_starve_nxt;
  logic                r_discard,     w_discard_nxt;
  logic                r_mport_req,   w_mport_req_nxt;
  logic                r_mport_we,    w_mport_we_nxt;
  logic [ADDR_W-1:0]   r_mport_addr,  w_mport_addr_nxt;
  logic [DATA_W-1:0]   r_mport_wdata, w_mport_wdata_nxt;
  logic [DATA_W-1:0]   r_if_rdata,    w_if_rdata_nxt;
  logic                r_if_valid,    w_if_valid_nxt;
  logic [DATA_W-1:0]   r_mem_rdata,   w_mem_rdata_nxt;
  logic                r_mem_valid,   w_mem_valid_nxt;
  logic                w_if_wins;

  assign mport_req_o   = r_mport_req;
  assign mport_we_o    = r_mport_we;
  assign mport_addr_o  = r_mport_addr;
  assign mport_wdata_o = r_mport_wdata;
  assign if_rdata_o    = r_if_rdata;
  assign if_valid_o    = r_if_valid;
  assign mem_rdata_o   = r_mem_rdata;
  assign mem_valid_o   = r_mem_valid;

  // Requesters are frozen until their completion pulse.
  assign if_stall_o  = if_req_i & ~r_if_valid;
  assign mem_stall_o = mem_req_i & ~r_mem_valid;

  // IF takes the port when alone, or when MEM has starved it long enough.
  assign w_if_wins = if_req_i & (~mem_req_i | (r_starve == STARVE_LIM));

  // Next-state, grant and completion logic.
  always_comb begin
    w_state_nxt       = r_state;
    w_starve_nxt      = r_starve;
    w_discard_nxt     = r_discard;
    w_mport_req_nxt   = r_mport_req;
    w_mport_we_nxt    = r_mport_we;
    w_mport_addr_nxt  = r_mport_addr;
    w_mport_wdata_nxt = r_mport_wdata;
    w_if_rdata_nxt    = r_if_rdata;
    w_if_valid_nxt    = 1'b0;
    w_mem_rdata_nxt   = r_mem_rdata;
    w_mem_valid_nxt   = 1'b0;

    unique case (r_state)
      IDLE: begin
        w_discard_nxt = 1'b0;
        if (w_if_wins) begin
          w_state_nxt       = SERVE_IF;
          w_starve_nxt      = '0;
          w_mport_req_nxt   = 1'b1;
          w_mport_we_nxt    = 1'b0;
          w_mport_addr_nxt  = if_addr_i;
          w_mport_wdata_nxt = '0;
        end else if (mem_req_i) begin
          w_state_nxt       = SERVE_MEM;
          w_mport_req_nxt   = 1'b1;
          w_mport_we_nxt    = mem_we_i;
          w_mport_addr_nxt  = mem_addr_i;
          w_mport_wdata_nxt = mem_wdata_i;
          if (!if_req_i) begin
            w_starve_nxt = '0;
          end else if (r_starve < STARVE_LIM) begin
            w_starve_nxt = r_starve + CNT_W'(1);
          end
        end
      end
      SERVE_IF: begin
        if (flush_i) begin
          w_discard_nxt = 1'b1;
        end
        if (mport_ack_i) begin
          w_state_nxt     = IDLE;
          w_mport_req_nxt = 1'b0;
          w_discard_nxt   = 1'b0;
          if (!(r_discard || flush_i)) begin
            w_if_rdata_nxt = mport_rdata_i;
            w_if_valid_nxt = 1'b1;
          end
        end
      end
      SERVE_MEM: begin
        if (mport_ack_i) begin
          w_state_nxt     = IDLE;
          w_mport_req_nxt = 1'b0;
          w_mem_valid_nxt = 1'b1;
          if (!r_mport_we) begin
            w_mem_rdata_nxt = mport_rdata_i;
          end
        end
      end
      default: begin
        w_state_nxt     = IDLE;
        w_mport_req_nxt = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset abandons any transfer in flight.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_starve      <= '0;
      r_discard     <= 1'b0;
      r_mport_req   <= 1'b0;
      r_mport_we    <= 1'b0;
      r_mport_addr  <= '0;
      r_mport_wdata <= '0;
      r_if_rdata    <= '0;
      r_if_valid    <= 1'b0;
      r_mem_rdata   <= '0;
      r_mem_valid   <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_starve      <= w_starve_nxt;
      r_discard     <= w_discard_nxt;
      r_mport_req   <= w_mport_req_nxt;
      r_mport_we    <= w_mport_we_nxt;
      r_mport_addr  <= w_mport_addr_nxt;
      r_mport_wdata <= w_mport_wdata_nxt;
      r_if_rdata    <= w_if_rdata_nxt;
      r_if_valid    <= w_if_valid_nxt;
      r_mem_rdata   <= w_mem_rdata_nxt;
      r_mem_valid   <= w_mem_valid_nxt;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed table, multi-cycle corner cases, then
// random traffic checked against a transaction-level model.
module tb_mem_port_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SM = 4;

  logic          clk_i = 1'b0;
  logic          rst_n;
  logic          if_req_i, flush_i, mem_req_i, mem_we_i, mport_ack_i;
  logic [AW-1:0] if_addr_i, mem_addr_i;
  logic [DW-1:0] mem_wdata_i, mport_rdata_i;
  logic [DW-1:0] if_rdata_o, mem_rdata_o, mport_wdata_o;
  logic [AW-1:0] mport_addr_o;
  logic          if_valid_o, if_stall_o, mem_valid_o, mem_stall_o;
  logic          mport_req_o, mport_we_o;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SM)) dut (
    .clk_i(clk_i), .rst_n(rst_n),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o),
    .if_valid_o(if_valid_o), .if_stall_o(if_stall_o), .flush_i(flush_i),
    .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i),
    .mem_wdata_i(mem_wdata_i), .mem_rdata_o(mem_rdata_o),
    .mem_valid_o(mem_valid_o), .mem_stall_o(mem_stall_o),
    .mport_req_o(mport_req_o), .mport_we_o(mport_we_o),
    .mport_addr_o(mport_addr_o), .mport_wdata_o(mport_wdata_o),
    .mport_ack_i(mport_ack_i), .mport_rdata_i(mport_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mem [256];
  int          ack_delay = 0;
  bit          rsp_en    = 1'b0;
  bit          rnd_delay = 1'b0;
  logic [31:0] exp_if_rdata  = '0;
  logic [31:0] exp_mem_rdata = '0;

  typedef struct {
    bit          is_mem;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          delay;
    bit          flush;
    logic [31:0] exp_rdata;
    int          exp_lat;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] pattern(input logic [31:0] addr);
    logic [7:0] idx;
    idx = addr[9:2];
    return 32'hA500_0000 + 32'(idx);
  endfunction

  // Memory responder: acks ack_delay cycles after it first sees a request.
  initial begin
    int wait_cnt;
    logic [7:0] idx;
    wait_cnt = 0;
    forever begin
      @(negedge clk_i);
      if (!rsp_en) begin
        wait_cnt = 0;
      end else if (mport_ack_i) begin
        mport_ack_i = 1'b0;
      end else if (mport_req_o) begin
        if (wait_cnt >= ack_delay) begin
          idx = mport_addr_o[9:2];
          mport_ack_i = 1'b1;
          if (mport_we_o) begin
            mem[idx]      = mport_wdata_o;
            mport_rdata_i = $urandom;
          end else begin
            mport_rdata_i = mem[idx];
          end
          wait_cnt = 0;
          if (rnd_delay) ack_delay = $urandom_range(0, 3);
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // One complete transaction from the table, started at a falling edge.
  task automatic run_txn(input vec_t v);
    int          lat;
    bit          seen, got, vld, stl;
    logic [31:0] cap_addr, cap_wd;
    logic        cap_we;
    ack_delay = v.delay;
    flush_i   = v.flush;
    if (v.is_mem) begin
      mem_req_i = 1'b1; mem_we_i = v.we; mem_addr_i = v.addr; mem_wdata_i = v.wdata;
    end else begin
      if_req_i = 1'b1; if_addr_i = v.addr;
    end
    lat = 0; seen = 1'b0; got = 1'b0;
    cap_addr = '0; cap_wd = '0; cap_we = 1'b0;
    while (!got && lat < 50) begin
      @(negedge clk_i);
      lat++;
      vld = v.is_mem ? mem_valid_o : if_valid_o;
      stl = v.is_mem ? mem_stall_o : if_stall_o;
      if (mport_req_o && !seen) begin
        seen = 1'b1; cap_addr = mport_addr_o; cap_we = mport_we_o; cap_wd = mport_wdata_o;
      end
      chk("txn_stall", 32'(stl), 32'(!vld));
      got = vld;
    end
    if_req_i = 1'b0; mem_req_i = 1'b0; flush_i = 1'b0;
    chk("txn_latency", 32'(lat), 32'(v.exp_lat));
    chk("txn_port_addr", cap_addr, v.addr);
    chk("txn_port_we", 32'(cap_we), 32'(v.is_mem && v.we));
    if (v.is_mem && v.we) chk("txn_port_wdata", cap_wd, v.wdata);
    chk("txn_rdata", v.is_mem ? mem_rdata_o : if_rdata_o, v.exp_rdata);
    if (v.is_mem && !v.we) exp_mem_rdata = v.exp_rdata;
    if (!v.is_mem) exp_if_rdata = v.exp_rdata;
    @(negedge clk_i);
    chk("txn_single_pulse", 32'(v.is_mem ? mem_valid_o : if_valid_o), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          prev, done, mem_stop;
    int          grants, cyc, valids;
    int          gk [6];
    int          exp_gk [6];
    // random phase state
    logic [31:0] model_mem [256];
    bit          if_act, mem_act, r_we, pre_if, pre_mem, exp_mem_win, is_mem_grant;
    logic [31:0] r_if_addr, r_mem_addr, r_mem_wd, p_addr, p_wd;
    logic        p_we;
    int          if_wait, mem_wait, streak, n_grants;

    for (int i = 0; i < 256; i++) mem[i] = 32'hA500_0000 + 32'(i);
    mem[16] = 32'h2002_000A;

    vecs[0] = '{1'b0, 1'b0, 32'h40,  32'h0,         3, 1'b0, 32'h2002_000A, 5};
    vecs[1] = '{1'b1, 1'b1, 32'h20,  32'hDEAD_BEEF, 1, 1'b0, 32'h0,         3};
    vecs[2] = '{1'b1, 1'b0, 32'h20,  32'h0,         0, 1'b0, 32'hDEAD_BEEF, 2};
    vecs[3] = '{1'b0, 1'b0, 32'h44,  32'h0,         0, 1'b0, 32'hA500_0011, 2};
    vecs[4] = '{1'b1, 1'b0, 32'h80,  32'h0,         2, 1'b0, 32'hA500_0020, 4};
    vecs[5] = '{1'b1, 1'b1, 32'h84,  32'h1234_5678, 0, 1'b0, 32'hA500_0020, 2};
    vecs[6] = '{1'b0, 1'b0, 32'h84,  32'h0,         1, 1'b0, 32'h1234_5678, 3};
    vecs[7] = '{1'b1, 1'b0, 32'h3FC, 32'h0,         5, 1'b0, 32'hA500_00FF, 7};
    vecs[8] = '{1'b1, 1'b0, 32'h60,  32'h0,         1, 1'b1, 32'hA500_0018, 3};

    rst_n = 1'b0; if_req_i = 1'b0; flush_i = 1'b0; mem_req_i = 1'b0; mem_we_i = 1'b0;
    if_addr_i = '0; mem_addr_i = '0; mem_wdata_i = '0; mport_ack_i = 1'b0; mport_rdata_i = '0;

    // Reset state
    repeat (3) @(negedge clk_i);
    chk("rst_mport_req", 32'(mport_req_o), 0);
    chk("rst_mport_we", 32'(mport_we_o), 0);
    chk("rst_mport_addr", mport_addr_o, 0);
    chk("rst_mport_wdata", mport_wdata_o, 0);
    chk("rst_valids", 32'({if_valid_o, mem_valid_o}), 0);
    chk("rst_rdata", if_rdata_o | mem_rdata_o, 0);
    rst_n = 1'b1;
    rsp_en = 1'b1;
    @(negedge clk_i);

    // Directed single transactions
    for (int i = 0; i < 9; i++) run_txn(vecs[i]);

    // Simultaneous IF and MEM write: MEM first, then IF
    ack_delay = 0;
    if_req_i = 1'b1; if_addr_i = 32'h48;
    mem_req_i = 1'b1; mem_we_i = 1'b1; mem_addr_i = 32'h10; mem_wdata_i = 32'h55;
    prev = 1'b0; grants = 0;
    for (int c = 0; c < 40 && (if_req_i || mem_req_i); c++) begin
      @(negedge clk_i);
      if (mport_req_o && !prev) begin
        grants++;
        if (grants == 1) begin
          chk("conflict_first_addr", mport_addr_o, 32'h10);
          chk("conflict_first_we", 32'(mport_we_o), 1);
          chk("conflict_first_wdata", mport_wdata_o, 32'h55);
          chk("conflict_loser_stall", 32'(if_stall_o), 1);
        end else if (grants == 2) begin
          chk("conflict_second_addr", mport_addr_o, 32'h48);
          chk("conflict_second_we", 32'(mport_we_o), 0);
        end
      end
      if (mem_valid_o) begin
        mem_req_i = 1'b0;
        chk("conflict_mem_rdata_kept", mem_rdata_o, exp_mem_rdata);
      end
      if (if_valid_o) begin
        if_req_i = 1'b0;
        chk("conflict_if_rdata", if_rdata_o, 32'hA500_0012);
        exp_if_rdata = 32'hA500_0012;
      end
      prev = mport_req_o;
    end
    chk("conflict_grants", 32'(grants), 2);
    chk("conflict_idle", 32'({if_req_i, mem_req_i}), 0);
    @(negedge clk_i);

    // Starvation: MEM held continuously while IF waits
    ack_delay = 0;
    exp_gk = '{1, 1, 1, 1, 0, 1};
    gk = '{default: -1};
    mem_req_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h0;
    if_req_i = 1'b1; if_addr_i = 32'h4C;
    prev = 1'b0; grants = 0; mem_stop = 1'b0;
    for (int c = 0; c < 100 && (if_req_i || mem_req_i); c++) begin
      @(negedge clk_i);
      if (mport_req_o && !prev) begin
        if (grants < 6) gk[grants] = (mport_addr_o == 32'h4C) ? 0 : 1;
        grants++;
        if (grants >= 6) mem_stop = 1'b1;
      end
      if (if_valid_o) begin
        if_req_i = 1'b0;
        chk("starve_if_rdata", if_rdata_o, 32'hA500_0013);
        exp_if_rdata = 32'hA500_0013;
      end
      if (mem_valid_o && mem_stop) mem_req_i = 1'b0;
      prev = mport_req_o;
    end
    for (int i = 0; i < 6; i++) chk($sformatf("starve_grant%0d_is_mem", i), 32'(gk[i]), 32'(exp_gk[i]));
    exp_mem_rdata = 32'hA500_0000;
    chk("starve_mem_rdata", mem_rdata_o, exp_mem_rdata);
    @(negedge clk_i);

    // Flush while the fetch is on the port
    ack_delay = 2;
    if_req_i = 1'b1; if_addr_i = 32'h50;
    done = 1'b0; valids = 0; cyc = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk_i);
      if (if_valid_o) valids++;
      if (mport_req_o) cyc++;
      if (flush_i) flush_i = 1'b0;
      if (mport_req_o && !done) begin
        flush_i = 1'b1; if_req_i = 1'b0; done = 1'b1;
      end
    end
    chk("flush_no_valid", 32'(valids), 0);
    chk("flush_transfer_cycles", 32'(cyc), 3);
    chk("flush_if_rdata_kept", if_rdata_o, exp_if_rdata);
    chk("flush_port_idle", 32'(mport_req_o), 0);
    run_txn('{1'b0, 1'b0, 32'h54, 32'h0, 1, 1'b0, 32'hA500_0015, 3});

    // Flush arriving together with the ack
    rsp_en = 1'b0;
    if_req_i = 1'b1; if_addr_i = 32'h58;
    @(negedge clk_i);
    chk("flushack_granted", 32'(mport_req_o), 1);
    mport_ack_i = 1'b1; mport_rdata_i = 32'hBAD0_BAD0; flush_i = 1'b1;
    @(negedge clk_i);
    mport_ack_i = 1'b0; flush_i = 1'b0; if_req_i = 1'b0;
    valids = 0;
    for (int c = 0; c < 3; c++) begin
      if (if_valid_o) valids++;
      @(negedge clk_i);
    end
    chk("flushack_no_valid", 32'(valids), 0);
    chk("flushack_if_rdata_kept", if_rdata_o, exp_if_rdata);
    chk("flushack_port_idle", 32'(mport_req_o), 0);

    // Reset in the middle of a MEM transfer, then a stray ack
    mem_req_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h8;
    @(negedge clk_i);
    chk("rstmid_granted", 32'(mport_req_o), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid_req_drop", 32'(mport_req_o), 0);
    chk("rstmid_addr_clear", mport_addr_o, 0);
    chk("rstmid_if_rdata_clear", if_rdata_o, 0);
    mem_req_i = 1'b0;
    @(negedge clk_i);
    rst_n = 1'b1;
    @(negedge clk_i);
    mport_ack_i = 1'b1; mport_rdata_i = 32'h1111_2222;
    @(negedge clk_i);
    mport_ack_i = 1'b0;
    valids = 0;
    for (int c = 0; c < 4; c++) begin
      valids += int'(if_valid_o) + int'(mem_valid_o) + int'(mport_req_o);
      @(negedge clk_i);
    end
    chk("rstmid_stray_ack_ignored", 32'(valids), 0);
    chk("rstmid_mem_rdata_clear", mem_rdata_o, 0);
    exp_if_rdata = '0; exp_mem_rdata = '0;

    // Random traffic: IF reads the upper half of memory, MEM owns the lower half
    for (int i = 0; i < 256; i++) model_mem[i] = mem[i];
    rsp_en = 1'b1; rnd_delay = 1'b1; ack_delay = 1;
    if_act = 1'b0; mem_act = 1'b0; r_we = 1'b0;
    r_if_addr = '0; r_mem_addr = '0; r_mem_wd = '0;
    if_wait = 0; mem_wait = 0; streak = 0; n_grants = 0;
    pre_if = 1'b0; pre_mem = 1'b0; prev = 1'b0;
    p_addr = '0; p_we = 1'b0; p_wd = '0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk_i);
      if (mport_req_o && !prev) begin
        n_grants++;
        is_mem_grant = (mport_addr_o < 32'h200);
        exp_mem_win  = pre_mem && !(pre_if && streak == int'(SM));
        chk("rnd_grant_winner_is_mem", 32'(is_mem_grant), 32'(exp_mem_win));
        if (is_mem_grant) begin
          chk("rnd_mem_grant_addr", mport_addr_o, r_mem_addr);
          chk("rnd_mem_grant_we", 32'(mport_we_o), 32'(r_we));
          if (r_we) chk("rnd_mem_grant_wdata", mport_wdata_o, r_mem_wd);
          streak = pre_if ? ((streak < int'(SM)) ? streak + 1 : streak) : 0;
        end else begin
          chk("rnd_if_grant_addr", mport_addr_o, r_if_addr);
          chk("rnd_if_grant_we", 32'(mport_we_o), 0);
          streak = 0;
        end
      end else if (mport_req_o && prev) begin
        chk("rnd_port_stable", {mport_addr_o[30:0], mport_we_o} ^ mport_wdata_o,
            {p_addr[30:0], p_we} ^ p_wd);
      end
      chk("rnd_if_stall", 32'(if_stall_o), 32'(if_req_i && !if_valid_o));
      chk("rnd_mem_stall", 32'(mem_stall_o), 32'(mem_req_i && !mem_valid_o));
      if (if_valid_o) begin
        chk("rnd_if_valid_expected", 32'(if_act), 1);
        chk("rnd_if_rdata", if_rdata_o, model_mem[r_if_addr[9:2]]);
        if_act = 1'b0; if_req_i = 1'b0;
      end
      if (mem_valid_o) begin
        chk("rnd_mem_valid_expected", 32'(mem_act), 1);
        if (r_we) begin
          chk("rnd_mem_rdata_kept", mem_rdata_o, exp_mem_rdata);
          model_mem[r_mem_addr[9:2]] = r_mem_wd;
        end else begin
          exp_mem_rdata = model_mem[r_mem_addr[9:2]];
          chk("rnd_mem_rdata", mem_rdata_o, exp_mem_rdata);
        end
        mem_act = 1'b0; mem_req_i = 1'b0;
      end
      if (if_act) if_wait++;
      if (mem_act) mem_wait++;
      if (if_wait > 100 || mem_wait > 100) begin
        chk("rnd_request_timeout", 32'(if_wait > 100 || mem_wait > 100), 0);
        break;
      end
      if (!if_act && c < 2900 && $urandom_range(0, 3) == 0) begin
        if_act = 1'b1; if_wait = 0;
        r_if_addr = 32'h200 | (32'($urandom_range(0, 127)) << 2);
        if_req_i = 1'b1; if_addr_i = r_if_addr;
      end
      if (!mem_act && c < 2900 && $urandom_range(0, 2) == 0) begin
        mem_act = 1'b1; mem_wait = 0;
        r_we = 1'($urandom_range(0, 1));
        r_mem_addr = 32'($urandom_range(0, 127)) << 2;
        r_mem_wd = $urandom;
        mem_req_i = 1'b1; mem_we_i = r_we; mem_addr_i = r_mem_addr; mem_wdata_i = r_mem_wd;
      end
      pre_if = if_req_i; pre_mem = mem_req_i;
      prev = mport_req_o; p_addr = mport_addr_o; p_we = mport_we_o; p_wd = mport_wdata_o;
    end
    chk("rnd_all_completed", 32'({if_act, mem_act}), 0);
    chk("rnd_some_grants", 32'(n_grants > 200), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter: ADDR_W, default 32, address width of all ports.
REQ-002 Parameter: DATA_W, default 32, data width of all ports.
REQ-003 Parameter: STARVE_MAX, default 4, consecutive MEM grants allowed while IF waits.
REQ-004 The ports SHALL be exactly as follows:
- clk_i  in  1  sole clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- if_req_i  in  1  fetch request, held until if_valid_o.
- if_addr_i  in  ADDR_W  fetch address, stable while if_req_i is high.
- if_rdata_o  out  DATA_W  fetched instruction.
- if_valid_o  out  1  one-cycle pulse; if_rdata_o is valid.
- if_stall_o  out  1  freeze PC and IF/ID.
- flush_i  in  1  discard any in-flight fetch (branch/jump taken).
- mem_req_i  in  1  data-stage request, held until mem_valid_o.
- mem_we_i  in  1  1 = write, 0 = read.
- mem_addr_i  in  ADDR_W  data address.
- mem_wdata_i  in  DATA_W  store data.
- mem_rdata_o  out  DATA_W  load data.
- mem_valid_o  out  1  one-cycle pulse; access complete.
- mem_stall_o  out  1  freeze MEM stage and earlier.
- mport_req_o  out  1  shared-memory request.
- mport_we_o  out  1  shared-memory write enable.
- mport_addr_o  out  ADDR_W  shared-memory address.
- mport_wdata_o  out  DATA_W  shared-memory write data.
- mport_ack_i  in  1  access done; mport_rdata_i is valid in the same cycle.
- mport_rdata_i  in  DATA_W  shared-memory read data.

Function
REQ-005 FSM states SHALL be IDLE, SERVE_IF, SERVE_MEM; all outputs except the stalls SHALL be registered.
REQ-006 In IDLE with any request high, the arbiter SHALL grant at that edge: load the mport_* registers, set mport_req_o=1 and enter SERVE_IF or SERVE_MEM (request seen in cycle N gives mport_req_o in cycle N+1).
REQ-007 Priority: MEM SHALL win over IF, except when if_req_i=1 and starve_cnt==STARVE_MAX; then IF SHALL win.
REQ-008 starve_cnt (3 bits, saturating at STARVE_MAX) SHALL be updated on every grant:
- +1 on a MEM grant while if_req_i=1.
- cleared on an IF grant.
- cleared on a MEM grant while if_req_i=0.
REQ-009 mport_req_o, mport_we_o, mport_addr_o and mport_wdata_o SHALL hold stable until mport_ack_i is sampled high.
REQ-010 On the ack edge in SERVE_IF:
- capture mport_rdata_i into if_rdata_o.
- pulse if_valid_o in the next cycle.
- drop mport_req_o.
- return to IDLE.
REQ-011 On the ack edge in SERVE_MEM:
- pulse mem_valid_o in the next cycle.
- capture mport_rdata_i into mem_rdata_o only when mport_we_o=0; on writes mem_rdata_o is unchanged.
- drop mport_req_o.
- return to IDLE.
REQ-012 After each ack, IDLE SHALL last at least one cycle; there are no back-to-back grants.
REQ-013 if_stall_o SHALL be if_req_i & ~if_valid_o, and mem_stall_o SHALL be mem_req_i & ~mem_valid_o (both combinational).
REQ-014 flush_i handling:
- flush_i=1 in SERVE_IF SHALL set a discard flag; the transfer completes on the port, but if_valid_o is suppressed and if_rdata_o is unchanged.
- flush_i=1 in SERVE_IF coinciding with mport_ack_i SHALL also discard.
- flush_i in IDLE or SERVE_MEM SHALL have no effect.
- The discard flag SHALL clear on return to IDLE.
REQ-015 If a requester drops its request before its valid pulse, the started transfer SHALL still complete and its valid pulse SHALL still be issued (except a flushed IF, per REQ-014).
REQ-016 Simultaneous if_req_i and mem_req_i in IDLE SHALL produce exactly one grant, per REQ-007; the loser stays stalled.

Reset
REQ-017 While rst_n=0 (asynchronous), the following SHALL hold, with mport_req_o low immediately:
- state=IDLE, starve_cnt=0, discard flag=0.
- mport_req_o=0, mport_we_o=0, mport_addr_o=0, mport_wdata_o=0.
- if_valid_o=0, mem_valid_o=0, if_rdata_o=0, mem_rdata_o=0.
REQ-018 Reset asserted mid-transfer SHALL abandon the transfer; a late mport_ack_i after reset SHALL be ignored in IDLE.

Verification
REQ-019 Single fetch: if_req_i=1 with if_addr_i=0x40, ack 3 cycles after mport_req_o with rdata=0x2002000A -> mport_addr_o=0x40, we=0; if_valid_o pulses once with if_rdata_o=0x2002000A; if_stall_o=1 until that pulse.
REQ-020 Conflict: if_req_i and mem_req_i (write, addr 0x10, data 0x55) rise in the same cycle, immediate acks -> MEM granted first with mport_we_o=1, then IF; mem_rdata_o is unchanged.
REQ-021 Starvation: mem_req_i held high continuously while if_req_i=1 with STARVE_MAX=4 -> exactly 4 MEM grants, then 1 IF grant, then MEM resumes.
REQ-022 Flush: flush_i pulses during SERVE_IF, ack 2 cycles later -> no if_valid_o, if_rdata_o is unchanged, state returns to IDLE and the next IF request is served normally.
REQ-023 Reset mid-transfer: rst_n low while in SERVE_MEM -> mport_req_o=0 immediately; after release, a stray mport_ack_i produces no valid pulse.
REQ-024 Write-then-read: write 0xDEADBEEF to 0x20, then read 0x20 from a memory model -> mem_rdata_o=0xDEADBEEF with a single mem_valid_o pulse per access.
